// File: rtl/idct_pkg.sv
// Shared constants for the IDCT post-IFFT scaling stage.
// Holds the rounding-mode encodings and the source_error bit positions.
// No logic.
package idct_pkg;

   // Rounding modes; code 3 is handled as half-up.
   localparam logic [1:0] RND_TRUNC  = 2'd0;
   localparam logic [1:0] RND_HALFUP = 2'd1;
   localparam logic [1:0] RND_CONV   = 2'd2;

   // source_error bit positions
   localparam int ERR_SOP_OPEN = 0;   // sop arrived while a frame was open
   localparam int ERR_ORPHAN   = 1;   // sample arrived outside any frame

endpackage

// File: rtl/idct_round_sat.sv
// Purpose: round + arithmetic right shift (stage-1 side) and clamp to W_OUT (stage-2 side) for one component.
// Latency: purely combinational; the caller places its pipeline register between shifted and sh_q.
// Backpressure: none here, the caller owns the handshake.
// Ports: din/shift/rnd -> shifted (W_IN+1 bits); sh_q (registered shifted) -> dout, sat.
module idct_round_sat
   import idct_pkg::*;
#(
   parameter int W_IN    = 28,
   parameter int W_OUT   = 16,
   parameter int W_SHIFT = 5
) (
   input  logic [W_IN-1:0]    din,
   input  logic [W_SHIFT-1:0] shift,
   input  logic [1:0]         rnd,
   output logic [W_IN:0]      shifted,
   input  logic [W_IN:0]      sh_q,
   output logic [W_OUT-1:0]   dout,
   output logic               sat
);

   localparam int WX = W_IN + 1;

   logic [WX-1:0]      half;
   logic [WX-1:0]      ofs;
   logic [WX-1:0]      sum;
   logic [WX-W_OUT:0]  hi;

   // One extra bit of headroom: |din| + 2^(shift-1) cannot overflow W_IN+1 bits
   // because shift is clamped to W_IN-1 upstream.
   always_comb begin
      half = WX'(1) << (shift - W_SHIFT'(1));
      ofs  = '0;
      if (shift != '0) begin
         case (rnd)
            RND_TRUNC:  ofs = '0;
            RND_CONV:   ofs = half - WX'(1) + WX'(din[shift]);  // ties go to the even quotient
            RND_HALFUP: ofs = half;
            default:    ofs = half;
         endcase
      end
      sum     = {din[W_IN-1], din} + ofs;
      shifted = $signed(sum) >>> shift;
   end

   // The value fits W_OUT when all bits from the W_OUT sign bit upward agree.
   assign hi = sh_q[W_IN:W_OUT-1];

   always_comb begin
      dout = sh_q[W_OUT-1:0];
      sat  = 1'b0;
      if (!((&hi) || (~|hi))) begin
         sat  = 1'b1;
         dout = sh_q[W_IN] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
      end
   end

endmodule

// File: rtl/idct_scaling_pipe.sv
// Purpose: per-frame runtime right shift with rounding and saturation of complex IFFT samples, plus framing checks and saturation stats.
// Latency: 2 cycles sink transfer -> source_valid, 1 sample/cycle throughput.
// Backpressure: elastic 2-stage valid/ready; sink_ready = !s1_valid | s1 advance, combinational from source_ready only.
// Ports: sink_* in (sop/eop/valid/ready, real/imag), cfg_shift/cfg_round/fftpts_in sampled at sop;
//        source_* out aligned with data, sat_flag per sample, frame_sat_cnt/frame_sat_valid per frame.
module idct_scaling_pipe
   import idct_pkg::*;
#(
   parameter int W_IN    = 28,
   parameter int W_OUT   = 16,
   parameter int W_SHIFT = 5,
   parameter int W_CNT   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sink_valid,
   output logic               sink_ready,
   input  logic               sink_sop,
   input  logic               sink_eop,
   input  logic [W_IN-1:0]    sink_real,
   input  logic [W_IN-1:0]    sink_imag,
   input  logic [11:0]        fftpts_in,
   input  logic [W_SHIFT-1:0] cfg_shift,
   input  logic [1:0]         cfg_round,
   output logic               source_valid,
   input  logic               source_ready,
   output logic               source_sop,
   output logic               source_eop,
   output logic [W_OUT-1:0]   source_real,
   output logic [W_OUT-1:0]   source_imag,
   output logic [1:0]         source_error,
   output logic [11:0]        fftpts_out,
   output logic               sat_flag,
   output logic [W_CNT-1:0]   frame_sat_cnt,
   output logic               frame_sat_valid
);

   localparam logic [W_SHIFT-1:0] SHIFT_MAX = W_SHIFT'(W_IN - 1);

   logic               run;        // low in reset and for the first cycle after, keeps sink_ready 0
   logic               s1_valid;
   logic               s2_adv;
   logic               in_xfer;
   logic               out_xfer;

   logic               open_q;
   logic [W_SHIFT-1:0] shift_q;
   logic [1:0]         rnd_q;
   logic [11:0]        fft_q;

   logic [W_SHIFT-1:0] cur_shift;
   logic [1:0]         cur_rnd;
   logic [11:0]        cur_fft;
   logic [1:0]         cur_err;

   logic [W_IN:0]      real_sh, imag_sh;
   logic [W_IN:0]      s1_real, s1_imag;
   logic               s1_sop, s1_eop;
   logic [1:0]         s1_err;
   logic [11:0]        s1_fft;

   logic [W_OUT-1:0]   real_o, imag_o;
   logic               real_sat, imag_sat;

   logic [W_CNT-1:0]   cnt, cnt_base, cnt_inc;

   assign s2_adv     = !source_valid || source_ready;
   assign sink_ready = run && (!s1_valid || s2_adv);
   assign in_xfer    = sink_valid && sink_ready;
   assign out_xfer   = source_valid && source_ready;

   // sop takes fresh settings; every other sample reuses the latched ones.
   always_comb begin
      cur_shift = shift_q;
      cur_rnd   = rnd_q;
      cur_fft   = fft_q;
      cur_err   = '0;
      if (sink_sop) begin
         cur_shift             = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
         cur_rnd               = cfg_round;
         cur_fft               = fftpts_in;
         cur_err[ERR_SOP_OPEN] = open_q;
      end else begin
         cur_err[ERR_ORPHAN]   = !open_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   // An orphan eop leaves the frame closed; sop (re)opens unless it is also eop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         open_q  <= 1'b0;
         shift_q <= '0;
         rnd_q   <= '0;
         fft_q   <= '0;
      end else if (in_xfer) begin
         shift_q <= cur_shift;
         rnd_q   <= cur_rnd;
         fft_q   <= cur_fft;
         if (sink_sop || open_q) begin
            open_q <= !sink_eop;
         end
      end
   end

   idct_round_sat #(.W_IN(W_IN), .W_OUT(W_OUT), .W_SHIFT(W_SHIFT)) u_real (
      .din(sink_real), .shift(cur_shift), .rnd(cur_rnd), .shifted(real_sh),
      .sh_q(s1_real), .dout(real_o), .sat(real_sat)
   );

   idct_round_sat #(.W_IN(W_IN), .W_OUT(W_OUT), .W_SHIFT(W_SHIFT)) u_imag (
      .din(sink_imag), .shift(cur_shift), .rnd(cur_rnd), .shifted(imag_sh),
      .sh_q(s1_imag), .dout(imag_o), .sat(imag_sat)
   );

   // Stage 1: rounded and shifted value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_real  <= '0;
         s1_imag  <= '0;
         s1_sop   <= 1'b0;
         s1_eop   <= 1'b0;
         s1_err   <= '0;
         s1_fft   <= '0;
      end else begin
         if (sink_ready) begin
            s1_valid <= sink_valid;
         end
         if (in_xfer) begin
            s1_real <= real_sh;
            s1_imag <= imag_sh;
            s1_sop  <= sink_sop;
            s1_eop  <= sink_eop;
            s1_err  <= cur_err;
            s1_fft  <= cur_fft;
         end
      end
   end

   // Stage 2: saturated output register, frozen while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         source_valid <= 1'b0;
         source_real  <= '0;
         source_imag  <= '0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_error <= '0;
         fftpts_out   <= '0;
         sat_flag     <= 1'b0;
      end else if (s2_adv) begin
         source_valid <= s1_valid;
         if (s1_valid) begin
            source_real  <= real_o;
            source_imag  <= imag_o;
            source_sop   <= s1_sop;
            source_eop   <= s1_eop;
            source_error <= s1_err;
            fftpts_out   <= s1_fft;
            sat_flag     <= real_sat || imag_sat;
         end
      end
   end

   // Output sop discards any earlier partial count; the counter sticks at all-ones.
   always_comb begin
      cnt_base = source_sop ? '0 : cnt;
      cnt_inc  = cnt_base;
      if (sat_flag && !(&cnt_base)) begin
         cnt_inc = cnt_base + W_CNT'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt             <= '0;
         frame_sat_cnt   <= '0;
         frame_sat_valid <= 1'b0;
      end else begin
         frame_sat_valid <= 1'b0;
         if (out_xfer) begin
            if (source_eop) begin
               frame_sat_cnt   <= cnt_inc;
               frame_sat_valid <= 1'b1;
               cnt             <= '0;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_idct_scaling_pipe.sv
// Purpose: randomized + directed bench for idct_scaling_pipe with a queue-based scoreboard.
// Latency: checks 2-cycle latency while source_ready is held high.
// Backpressure: drives random source_ready and checks outputs hold while stalled.
module tb_idct_scaling_pipe;

   logic        clk;
   logic        rst_n;
   logic        sink_valid;
   logic        sink_ready;
   logic        sink_sop;
   logic        sink_eop;
   logic [27:0] sink_real;
   logic [27:0] sink_imag;
   logic [11:0] fftpts_in;
   logic [4:0]  cfg_shift;
   logic [1:0]  cfg_round;
   logic        source_valid;
   logic        source_ready;
   logic        source_sop;
   logic        source_eop;
   logic [15:0] source_real;
   logic [15:0] source_imag;
   logic [1:0]  source_error;
   logic [11:0] fftpts_out;
   logic        sat_flag;
   logic [15:0] frame_sat_cnt;
   logic        frame_sat_valid;

   idct_scaling_pipe #(.W_IN(28), .W_OUT(16), .W_SHIFT(5), .W_CNT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
      .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
      .cfg_shift(cfg_shift), .cfg_round(cfg_round),
      .source_valid(source_valid), .source_ready(source_ready), .source_sop(source_sop),
      .source_eop(source_eop), .source_real(source_real), .source_imag(source_imag),
      .source_error(source_error), .fftpts_out(fftpts_out), .sat_flag(sat_flag),
      .frame_sat_cnt(frame_sat_cnt), .frame_sat_valid(frame_sat_valid)
   );

   typedef struct {
      int         re;
      int         im;
      logic       sop;
      logic       eop;
      logic [1:0] err;
      logic [11:0] fft;
      logic       sat;
      int         cyc;
   } item_t;

   item_t exp_q[$];
   int    stat_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit bp_on = 0;
   bit lat_mode = 0;

   // reference-model frame state
   bit          m_open = 0;
   int          m_shift = 0;
   int          m_rnd = 0;
   logic [11:0] m_fft = '0;
   int          m_cnt = 0;

   // monitor state
   bit          pend = 0;
   int          pend_cnt = 0;
   int          pulse_count = 0;
   bit          held = 0;
   logic [15:0] h_re, h_im;
   logic        h_sop, h_eop, h_sat;
   logic [1:0]  h_err;
   logic [11:0] h_fft;

   int rnd_in[3]   = '{384, 640, -384};
   int rnd_exp[9]  = '{1, 2, 2, 2, 3, 2, -2, -1, -2};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Plain integer rounding: floor quotient, then adjust by remainder.
   function automatic longint ref_round(input logic [27:0] d, input int s, input int m);
      longint x, q, rem, half;
      x = $signed(d);
      if (s == 0) return x;
      q    = x >>> s;
      rem  = x - (q << s);
      half = longint'(1) << (s - 1);
      if (m == 1 && rem >= half) q = q + 1;
      if (m == 2 && (rem > half || (rem == half && q[0]))) q = q + 1;
      return q;
   endfunction

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic [27:0] rnd28();
      logic [27:0] v;
      v = 28'($urandom);
      v = v >> $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) v = -v;
      return v;
   endfunction

   task automatic send(input logic sop, input logic eop, input logic [27:0] re, input logic [27:0] im,
                       input logic [11:0] fft, input logic [4:0] sh, input logic [1:0] rnd,
                       input bit has_exp, input int exp_r, input int exp_i);
      item_t  it;
      int     n;
      longint vr, vi;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_real  = re;
      sink_imag  = im;
      fftpts_in  = fft;
      cfg_shift  = sh;
      cfg_round  = rnd;
      sink_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sink_ready && n < 300);
      if (!sink_ready) begin
         chk("sink_ready_timeout", sink_ready, 1);
         sink_valid = 1'b0;
         return;
      end
      if (sop) begin
         it.err  = {1'b0, m_open};
         m_shift = (int'(sh) > 27) ? 27 : int'(sh);
         m_rnd   = (rnd == 2'd3) ? 1 : int'(rnd);
         m_fft   = fft;
         m_open  = !eop;
      end else begin
         it.err = {!m_open, 1'b0};
         if (m_open) m_open = !eop;
      end
      vr     = ref_round(re, m_shift, m_rnd);
      vi     = ref_round(im, m_shift, m_rnd);
      it.sat = (clamp16(vr) != vr) || (clamp16(vi) != vi);
      it.re  = has_exp ? exp_r : int'(clamp16(vr));
      it.im  = has_exp ? exp_i : int'(clamp16(vi));
      it.sop = sop;
      it.eop = eop;
      it.fft = m_fft;
      it.cyc = cyc;
      if (sop) m_cnt = 0;
      if (it.sat && m_cnt < 65535) m_cnt++;
      if (eop) begin
         stat_q.push_back(m_cnt);
         m_cnt = 0;
      end
      exp_q.push_back(it);
      @(posedge clk);
      #1;
      sink_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sink_ready"}, sink_ready, 0);
      chk({tag, "_source_valid"}, source_valid, 0);
      chk({tag, "_source_real"}, source_real, 0);
      chk({tag, "_source_imag"}, source_imag, 0);
      chk({tag, "_source_sop"}, source_sop, 0);
      chk({tag, "_source_eop"}, source_eop, 0);
      chk({tag, "_source_error"}, source_error, 0);
      chk({tag, "_fftpts_out"}, fftpts_out, 0);
      chk({tag, "_sat_flag"}, sat_flag, 0);
      chk({tag, "_frame_sat_cnt"}, frame_sat_cnt, 0);
      chk({tag, "_frame_sat_valid"}, frame_sat_valid, 0);
   endtask

   // source_ready driver
   initial begin
      source_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         source_ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops expected items on each output transfer.
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pend) begin
               chk("frame_sat_valid", frame_sat_valid, 1);
               chk("frame_sat_cnt", frame_sat_cnt, pend_cnt);
               pend = 0;
            end else if (frame_sat_valid) begin
               chk("frame_sat_valid_idle", frame_sat_valid, 0);
            end
            if (frame_sat_valid) pulse_count++;
            if (held) begin
               chk("hold_valid", source_valid, 1);
               chk("hold_real", source_real, h_re);
               chk("hold_imag", source_imag, h_im);
               chk("hold_ctrl", {source_sop, source_eop, sat_flag, source_error, fftpts_out},
                   {h_sop, h_eop, h_sat, h_err, h_fft});
               held = 0;
            end
            if (source_valid && !source_ready) begin
               held  = 1;
               h_re  = source_real;
               h_im  = source_imag;
               h_sop = source_sop;
               h_eop = source_eop;
               h_sat = sat_flag;
               h_err = source_error;
               h_fft = fftpts_out;
            end
            if (source_valid && source_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output_queue_size", exp_q.size(), 1);
               end else begin
                  it = exp_q.pop_front();
                  chk("real", $signed(source_real), it.re);
                  chk("imag", $signed(source_imag), it.im);
                  chk("sop", source_sop, it.sop);
                  chk("eop", source_eop, it.eop);
                  chk("error", source_error, it.err);
                  chk("fftpts_out", fftpts_out, it.fft);
                  chk("sat_flag", sat_flag, it.sat);
                  if (lat_mode) chk("latency", cyc - it.cyc, 2);
                  if (it.eop) begin
                     pend = 1;
                     if (stat_q.size() == 0) chk("stat_queue_size", stat_q.size(), 1);
                     else pend_cnt = stat_q.pop_front();
                  end
               end
            end
         end
      end
   end

   initial begin
      int n;
      int len;
      int pulses_at;
      logic [4:0]  sh;
      logic [1:0]  rm;
      logic [11:0] ft;
      rst_n      = 1'b1;
      sink_valid = 1'b0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      sink_real  = '0;
      sink_imag  = '0;
      fftpts_in  = '0;
      cfg_shift  = '0;
      cfg_round  = '0;
      #1 rst_n = 1'b0;
      #2 check_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle(3);

      // rounding modes, shift 8, single-sample frames, no backpressure
      lat_mode = 1;
      for (int v = 0; v < 3; v++)
         for (int m = 0; m < 3; m++)
            send(1, 1, 28'(rnd_in[v]), 28'(0), 12'd16, 5'd8, 2'(m), 1, rnd_exp[v*3+m], 0);
      send(1, 1, 28'(640), 28'(0), 12'd16, 5'd8, 2'd3, 1, 3, 0);

      // saturation: clamp both ways, then exact max is not flagged
      send(1, 0, 28'(1 << 23), 28'(-(1 << 23) - 512), 12'd2, 5'd8, 2'd0, 1, 32767, -32768);
      send(0, 1, 28'(32767 * 256), 28'(0), 12'd2, 5'd8, 2'd0, 1, 32767, 0);

      // 16-sample frame with 5 clamped samples, then a clean frame
      for (int i = 0; i < 16; i++)
         send(i == 0, i == 15, (i % 3 == 0 && i < 15) ? 28'(1 << 26) : 28'(i * 100),
              28'(i * 7), 12'd16, 5'd8, 2'd0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         send(i == 0, i == 7, 28'(i * 300), -28'(i * 50), 12'd8, 5'd8, 2'd1, 0, 0, 0);
      idle(4);
      lat_mode = 0;

      // everything below under random backpressure
      bp_on = 1;

      // cfg_shift changes mid-frame are ignored; next sop picks them up
      send(1, 0, 28'(1000), 28'(3000), 12'd512, 5'd8, 2'd0, 0, 0, 0);
      for (int i = 1; i < 6; i++)
         send(0, i == 5, 28'(1000 + 97 * i), 28'(3000 - 61 * i), 12'd77, 5'd7, 2'd2, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         send(i == 0, i == 2, 28'(1000 + 33 * i), 28'(500), 12'd100, 5'd7, 2'd0, 0, 0, 0);

      // framing errors: sop inside open frame, then orphan samples
      send(1, 0, 28'(4096), 28'(0), 12'd4, 5'd4, 2'd0, 0, 0, 0);
      send(0, 0, 28'(4100), 28'(1), 12'd4, 5'd4, 2'd0, 0, 0, 0);
      send(1, 0, 28'(8192), 28'(2), 12'd5, 5'd5, 2'd1, 0, 0, 0);
      send(0, 1, 28'(8200), 28'(3), 12'd5, 5'd5, 2'd1, 0, 0, 0);
      send(0, 0, 28'(777), 28'(9), 12'd6, 5'd2, 2'd2, 0, 0, 0);
      send(0, 1, 28'(779), 28'(11), 12'd6, 5'd2, 2'd2, 0, 0, 0);

      // random frames with random idle gaps
      for (int f = 0; f < 3; f++) begin
         len = $urandom_range(4, 20);
         sh  = 5'($urandom_range(0, 31));
         rm  = 2'($urandom_range(0, 3));
         ft  = 12'($urandom);
         for (int i = 0; i < len; i++) begin
            send(i == 0, i == len - 1, rnd28(), rnd28(), ft, 5'($urandom), 2'($urandom), 0, 0, 0);
            if (i == 0) begin
               // keep sop settings fixed in the table; later cfg values are noise
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         end
         sh = sh;
      end

      // reset in the middle of a frame
      send(1, 0, 28'(1 << 25), 28'(5), 12'd9, 5'd6, 2'd1, 0, 0, 0);
      send(0, 0, 28'(123456), 28'(6), 12'd9, 5'd6, 2'd1, 0, 0, 0);
      send(0, 0, 28'(654321), 28'(7), 12'd9, 5'd6, 2'd1, 0, 0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_zero("midreset");
      exp_q.delete();
      stat_q.delete();
      m_open  = 0;
      m_shift = 0;
      m_rnd   = 0;
      m_fft   = '0;
      m_cnt   = 0;
      pend    = 0;
      held    = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      pulses_at = pulse_count;
      idle(20);
      chk("no_pulse_after_reset", pulse_count, pulses_at);

      // recovery: orphan with reset settings, then a normal frame
      send(0, 0, 28'(55), 28'(66), 12'd3, 5'd9, 2'd1, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         send(i == 0, i == 3, rnd28(), rnd28(), 12'd4, 5'd3, 2'd2, 0, 0, 0);

      n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      idle(4);
      chk("queue_drained", exp_q.size(), 0);
      chk("stats_drained", stat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
